// File: rtl/seq_detect_param.sv
// Serial sequence detector with a runtime-loadable, maskable PAT_W-bit pattern.
// It supports overlapping and non-overlapping matches and has a saturating match counter.
module seq_detect_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] PAT_RST  = PAT_W'(4'b0100),
  parameter logic [PAT_W-1:0] MASK_RST = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             in_en,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  input  logic             clr,
  output logic             valid,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic {FILL, ARMED} state_t;

  state_t            state, state_nx;
  logic [PAT_W-1:0]  pat, pat_nx;
  logic [PAT_W-1:0]  mask, mask_nx;
  logic [PAT_W-1:0]  hist, hist_nx, hist_n;
  logic [FILL_W-1:0] fill, fill_nx, fill_inc;
  logic              vld_p0, vld_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              sat, sat_nx;
  logic              accept, hit, match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FILL;
      pat    <= PAT_RST;
      mask   <= MASK_RST;
      hist   <= '0;
      fill   <= '0;
      vld_p0 <= 1'b0;
      cnt    <= '0;
      sat    <= 1'b0;
    end else begin
      state  <= state_nx;
      pat    <= pat_nx;
      mask   <= mask_nx;
      hist   <= hist_nx;
      fill   <= fill_nx;
      vld_p0 <= vld_nx;
      cnt    <= cnt_nx;
      sat    <= sat_nx;
    end
  end

  always_comb begin
    hist_n   = {hist[PAT_W-2:0], a};
    fill_inc = fill + FILL_W'(1);
    accept   = in_en && !pat_load;
    hit      = ((hist_n ^ pat) & mask) == '0;
    // The bit that completes the fill is compared like any armed bit.
    match    = accept && hit && ((state == ARMED) || (fill_inc == FILL_W'(PAT_W)));

    state_nx = state;
    pat_nx   = pat;
    mask_nx  = mask;
    hist_nx  = hist;
    fill_nx  = fill;
    vld_nx   = 1'b0;

    if (pat_load) begin
      pat_nx   = pat_in;
      mask_nx  = mask_in;
      hist_nx  = '0;
      fill_nx  = '0;
      state_nx = FILL;
    end else if (in_en) begin
      hist_nx = hist_n;
      if (state == FILL) begin
        fill_nx = fill_inc;
        if (fill_inc == FILL_W'(PAT_W)) state_nx = ARMED;
      end
      if (match) begin
        vld_nx = 1'b1;
        if (!overlap) begin
          hist_nx  = '0;
          fill_nx  = '0;
          state_nx = FILL;
        end
      end
    end

    // A clear and a match on the same edge leave the counter at one.
    cnt_nx = clr ? '0 : cnt;
    sat_nx = clr ? 1'b0 : sat;
    if (match) begin
      cnt_nx = sat_inc(cnt_nx);
      if (cnt_nx == '1) sat_nx = 1'b1;
    end
  end

  assign valid     = vld_p0;
  assign match_cnt = cnt;
  assign cnt_sat   = sat;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param (PAT_W=4, CNT_W=3): a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a = 1'b0;
  logic       in_en = 1'b0;
  logic       overlap = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic [3:0] mask_in = 4'b0000;
  logic       clr = 1'b0;
  logic       valid;
  logic [2:0] match_cnt;
  logic       cnt_sat;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_detect_param #(
    .PAT_W(4), .CNT_W(3), .PAT_RST(4'b0100), .MASK_RST(4'b1111)
  ) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .in_en(in_en), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in), .clr(clr),
    .valid(valid), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  // Reference model: it keeps the last accepted bits since the last restart, oldest first.
  int         m_bits[$];
  logic [3:0] m_pat;
  logic [3:0] m_mask;
  logic       m_valid;
  int         m_cnt;
  logic       m_sat;
  bit         m_hit;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_bits.delete();
      m_pat = 4'b0100; m_mask = 4'b1111;
      m_valid = 1'b0; m_cnt = 0; m_sat = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_hit = 1'b0;
      if (pat_load) begin
        m_pat = pat_in; m_mask = mask_in;
        m_bits.delete();
      end else if (in_en) begin
        m_bits.push_back(int'(a));
        if (m_bits.size() > 4) void'(m_bits.pop_front());
        if (m_bits.size() == 4) begin
          m_hit = 1'b1;
          for (int i = 0; i < 4; i++)
            if (m_mask[3-i] && (m_bits[i] != int'(m_pat[3-i]))) m_hit = 1'b0;
        end
      end
      if (clr) begin
        m_cnt = 0; m_sat = 1'b0;
      end
      if (m_hit) begin
        m_valid = 1'b1;
        if (m_cnt < 7) m_cnt++;
        if (m_cnt == 7) m_sat = 1'b1;
        if (!overlap) m_bits.delete();
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    check("model_valid", int'(valid), int'(m_valid));
    check("model_cnt", int'(match_cnt), m_cnt);
    check("model_sat", int'(cnt_sat), int'(m_sat));
  end

  task automatic step(input logic av, input logic ev);
    a = av; in_en = ev;
    @(posedge clk); #1;
    pat_load = 1'b0; clr = 1'b0; in_en = 1'b0;
  endtask

  task automatic stream(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) step(bits[i], 1'b1);
  endtask

  task automatic load(input logic [3:0] p, input logic [3:0] m);
    pat_load = 1'b1; pat_in = p; mask_in = m; clr = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    #12 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", int'(valid), 0);
    check("rst_cnt", int'(match_cnt), 0);
    check("rst_sat", int'(cnt_sat), 0);

    // Default pattern 0100 after reset.
    stream(4'b0100);
    check("t1_valid", int'(valid), 1);
    check("t1_cnt", int'(match_cnt), 1);
    step(1'b0, 1'b0);
    check("t1_pulse_end", int'(valid), 0);

    // Overlapping 1010 in 101010.
    overlap = 1'b1;
    load(4'b1010, 4'b1111);
    stream(4'b1010);
    check("t2_ov_v4", int'(valid), 1);
    step(1'b1, 1'b1); step(1'b0, 1'b1);
    check("t2_ov_v6", int'(valid), 1);
    check("t2_ov_cnt", int'(match_cnt), 2);
    overlap = 1'b0;
    load(4'b1010, 4'b1111);
    stream(4'b1010);
    check("t2_nov_v4", int'(valid), 1);
    step(1'b1, 1'b1); step(1'b0, 1'b1);
    check("t2_nov_v6", int'(valid), 0);
    check("t2_nov_cnt", int'(match_cnt), 1);

    // Masked pattern 1x x0 with an enable gap.
    load(4'b1000, 4'b1001);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("t3_gap1", int'(valid), 0);
    step(1'b1, 1'b0);
    check("t3_gap2", int'(valid), 0);
    step(1'b1, 1'b1); step(1'b0, 1'b1);
    check("t3_valid", int'(valid), 1);
    stream(4'b0110);
    check("t3_nomatch", int'(valid), 0);
    check("t3_cnt", int'(match_cnt), 1);

    // Saturation with an all-don't-care mask.
    overlap = 1'b1;
    load(4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check("t4_cnt7", int'(match_cnt), 7);
    check("t4_sat7", int'(cnt_sat), 1);
    step(1'b0, 1'b1); step(1'b1, 1'b1);
    check("t4_cnt9", int'(match_cnt), 7);
    check("t4_sat9", int'(cnt_sat), 1);
    clr = 1'b1;
    step(1'b0, 1'b1);
    check("t4_clr_valid", int'(valid), 1);
    check("t4_clr_cnt", int'(match_cnt), 1);
    check("t4_clr_sat", int'(cnt_sat), 0);

    // A load on the completing edge discards that bit.
    overlap = 1'b0;
    load(4'b0100, 4'b1111);
    step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    pat_load = 1'b1; pat_in = 4'b1001; mask_in = 4'b1111;
    step(1'b0, 1'b1);
    check("t5_load_valid", int'(valid), 0);
    stream(4'b1001);
    check("t5_valid", int'(valid), 1);
    check("t5_cnt", int'(match_cnt), 1);

    // Asynchronous reset in the middle of a pattern.
    load(4'b0100, 4'b1111);
    step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
    reset_n = 1'b0;
    #2;
    check("t6_async_cnt", int'(match_cnt), 0);
    reset_n = 1'b1;
    step(1'b0, 1'b1);
    check("t6_after_rst", int'(valid), 0);
    stream(4'b0100);
    check("t6_valid", int'(valid), 1);
    check("t6_cnt", int'(match_cnt), 1);
    step(1'b0, 1'b0);
    check("t6_pulse_end", int'(valid), 0);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
